// File: rtl/dmem_resp.sv
// ============================================================================
// dmem_resp : MA-stage data-memory responder, one fixed-latency word access at
//             a time. Optional feature macro: DMEM_MEMSRC_EN (WB->MA store fwd).
// Revision  : 1.0
// ============================================================================
`default_nettype none

module dmem_resp #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        MemSrc,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] wb_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                is_load_q, is_load_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [31:0]         ram [0:(2**ADDR_W)-1];

  logic                w_req_any;
  logic                w_req_ok;
  logic                w_ram_we;
  logic [31:0]         w_st_data;
  logic                unused_bits;

  assign w_req_any = MemRd | MemWr;
  assign w_req_ok  = (MemRd ^ MemWr) && (addr[1:0] == 2'b00);

`ifdef DMEM_MEMSRC_EN
  assign w_st_data   = MemSrc ? wb_data : wr_data;
  assign unused_bits = ^addr[31:ADDR_W+2];
`else
  assign w_st_data   = wr_data;
  assign unused_bits = ^{addr[31:ADDR_W+2], MemSrc, wb_data};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    is_load_d = is_load_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    w_ram_we  = 1'b0;
    stall     = 1'b0;
    addr_err  = 1'b0;
    rd_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_req_ok) begin
          idx_d     = addr[ADDR_W+1:2];
          is_load_d = MemRd;
          wdata_d   = w_st_data;
          cnt_d     = 4'(LAT - 1);
          state_d   = BUSY;
          stall     = 1'b1;
        end else if (w_req_any) begin
          addr_err  = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (is_load_q) rd_data_d = ram[idx_q];
          else           w_ram_we  = 1'b1;
        end
      end
      DONE: begin
        // Request lines still belong to the completing instruction here.
        rd_valid = is_load_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      is_load_q <= 1'b0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      is_load_q <= is_load_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAM contents survive reset; only the commit of a pending store is dropped.
  always_ff @(posedge clk) begin
    if (w_ram_we && rst_n) ram[idx_q] <= wdata_q;
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: vector table on a LAT=2 instance plus
// hand sequences (mid-access reset, LAT=1 back-to-back).
`default_nettype none

module tb_dmem_resp;

  localparam int LAT_A = 2;

`ifdef DMEM_MEMSRC_EN
  localparam logic [31:0] FWD_EXP = 32'hAAAA5555;
`else
  localparam logic [31:0] FWD_EXP = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_rd, a_wr, a_src, a_rd_valid, a_stall, a_err;
  logic [31:0] a_addr, a_wdata, a_wb, a_rd_data;
  logic        b_rst_n, b_rd, b_wr, b_src, b_rd_valid, b_stall, b_err;
  logic [31:0] b_addr, b_wdata, b_wb, b_rd_data;

  dmem_resp #(.ADDR_W(10), .LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .MemRd(a_rd), .MemWr(a_wr), .MemSrc(a_src),
    .addr(a_addr), .wr_data(a_wdata), .wb_data(a_wb), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .stall(a_stall), .addr_err(a_err)
  );

  dmem_resp #(.ADDR_W(10), .LAT(1)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .MemRd(b_rd), .MemWr(b_wr), .MemSrc(b_src),
    .addr(b_addr), .wr_data(b_wdata), .wb_data(b_wb), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .stall(b_stall), .addr_err(b_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wbdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        scramble;
  } vec_t;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic clear_a();
    a_rd = 1'b0; a_wr = 1'b0; a_src = 1'b0;
    a_addr = 32'd0; a_wdata = 32'd0; a_wb = 32'd0;
  endtask

  // Drive one request on instance A, hold it while stall is high, score results.
  task automatic access_a(input vec_t v, input string name);
    int  stall_cnt = 0;
    bit  err_seen  = 0;
    bit  vld_seen  = 0;
    bit  done      = 0;
    bit  is_load;
    is_load = v.rd && !v.wr && !v.exp_err;
    a_rd = v.rd; a_wr = v.wr; a_src = v.src;
    a_addr = v.addr; a_wdata = v.wdata; a_wb = v.wbdata;
    if (is_load) sb_q.push_back(v.exp_rd);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (a_stall) stall_cnt++;
      if (a_err) err_seen = 1;
      if (a_rd_valid) begin
        vld_seen = 1;
        if (sb_q.size() == 0) check({name, " unexpected rd_valid"}, 32'd1, 32'd0);
        else check({name, " rd_data"}, a_rd_data, sb_q.pop_front());
      end
      if (!a_stall) done = 1;
      @(posedge clk); #1;
      if (cyc == 0 && v.scramble) begin
        a_addr  = $urandom;
        a_wdata = $urandom;
      end
    end
    clear_a();
    if (!done) check({name, " timeout"}, 32'd0, 32'd1);
    if (is_load) last_rd = v.exp_rd;
    check({name, " stall cycles"}, 32'(stall_cnt), v.exp_err ? 32'd0 : 32'(LAT_A + 1));
    check({name, " addr_err"}, 32'(err_seen), 32'(v.exp_err));
    check({name, " rd_valid"}, 32'(vld_seen), 32'(is_load));
    @(negedge clk);
    check({name, " rd_data held"}, a_rd_data, last_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[16];
    logic [5:0]  exp_st;
    logic [5:0]  exp_vl;

    //            rd wr src addr            wdata          wbdata         err exp_rd         scr
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h0, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0012, 32'h0,        32'h0, 1'b1, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h1111,     32'h0, 1'b1, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_1004, 32'h0000_1234, 32'h0, 1'b0, 32'h0,       1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0,        32'h0, 1'b0, 32'h0000_1234, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0055, 32'h0, 1'b0, 32'h0,       1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h0, 1'b0, 32'h0000_0055, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'hCAFE0001, 32'h0, 1'b0, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'hF000_0FFC, 32'h0,        32'h0, 1'b0, 32'hCAFE0001, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0099, 32'h0, 1'b0, 32'h0,       1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h0, 1'b0, 32'h0000_0099, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0,   32'hAAAA5555, 1'b0, 32'h0,      1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0,        32'h0, 1'b0, FWD_EXP,      1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0000_0043, 32'hBAD0BAD0, 32'h0, 1'b1, 32'h0,        1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h0, 1'b0, 32'h0000_0099, 1'b0};

    clear_a();
    b_rd = 1'b0; b_wr = 1'b0; b_src = 1'b0;
    b_addr = 32'd0; b_wdata = 32'd0; b_wb = 32'd0;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    @(negedge clk);
    check("reset rd_data", a_rd_data, 32'd0);
    check("reset rd_valid", 32'(a_rd_valid), 32'd0);
    check("reset stall", 32'(a_stall), 32'd0);
    check("reset addr_err", 32'(a_err), 32'd0);
    check("reset b rd_data", b_rd_data, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) access_a(tbl[i], $sformatf("vec%0d", i));

    // Reset during the first BUSY cycle of a store: the store must be dropped.
    a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'h77;
    @(negedge clk);
    check("midrst accept stall", 32'(a_stall), 32'd1);
    @(posedge clk); #1;
    a_rst_n = 1'b0;
    clear_a();
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst stall c%0d", c), 32'(a_stall), 32'd0);
      check($sformatf("midrst rd_valid c%0d", c), 32'(a_rd_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("midrst rd_data", a_rd_data, 32'd0);
    last_rd = 32'd0;
    access_a('{1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 32'h55, 1'b0}, "midrst load");

    // LAT=1 back-to-back: store, junk store in DONE (ignored), then load.
    exp_st = 6'b011011;
    exp_vl = 6'b100000;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 1:    begin b_rd = 1'b0; b_wr = 1'b1; b_addr = 32'h8; b_wdata = 32'h5A5A; end
        2:       begin b_rd = 1'b0; b_wr = 1'b1; b_addr = 32'h8; b_wdata = 32'hBAD;  end
        default: begin b_rd = 1'b1; b_wr = 1'b0; b_addr = 32'h8; b_wdata = 32'h0;    end
      endcase
      if (c == 3) sb_q.push_back(32'h5A5A);
      @(negedge clk);
      check($sformatf("b2b stall c%0d", c), 32'(b_stall), 32'(exp_st[c]));
      check($sformatf("b2b rd_valid c%0d", c), 32'(b_rd_valid), 32'(exp_vl[c]));
      if (b_rd_valid) begin
        if (sb_q.size() == 0) check("b2b unexpected rd_valid", 32'd1, 32'd0);
        else check("b2b rd_data", b_rd_data, sb_q.pop_front());
      end
      @(posedge clk); #1;
    end
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'd0;
    @(negedge clk);
    check("b2b idle stall", 32'(b_stall), 32'd0);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
